mb_alu: RTL and testbench
=========================

# mb_alu

Serial multi-byte ALU for the sm83 core and its successors. It processes an N-byte operand pair over an 8-bit datapath, one byte per clock, least-significant byte first, chaining carry between bytes. It produces SM83-convention Z/N/H/C flags for the full-width result. It sits beside the byte ALU and serves 16-bit and wider arithmetic (ADD HL,rr, SP offsets, wide compares) without widening the core adder.

## Interface
Parameters:
- NBYTES, 2, operand width in bytes; legal range 1..8.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- abort  in  1  cancel the operation in progress; effective only in RUN.
- op  in  3  0 ADD, 1 ADC, 2 SUB, 3 SBC, 4 AND, 5 XOR, 6 OR, 7 CP.
- c_in  in  1  incoming carry flag; used by ADC/SBC only.
- a  in  8*NBYTES  accumulator operand; latched on accept.
- b  in  8*NBYTES  argument operand; latched on accept.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle completion strobe.
- res  out  8*NBYTES  registered result.
- f_z, f_n, f_h, f_c  out  1 each  registered flags.

## Operation
- FSM states are IDLE, RUN and DONE. The reset state is IDLE.
- IDLE: if start=1, latch a, b, op and c_in, clear the byte index and go to RUN. Otherwise stay in IDLE.
- RUN: on each edge, compute byte i, store it into the working result, and carry the chain to byte i+1.
  - After byte NBYTES-1, go to DONE.
  - If abort=1, go to IDLE with no done. res and flags keep their previous values. The working result is discarded.
- DONE: done=1, and res and flags update on entry to DONE.
  - If start=1 in DONE, accept the new operation and go directly to RUN (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored; there is no queue.
- Carry into byte 0:
  - ADD: 0.
  - ADC: c_in.
  - SUB and CP: 1.
  - SBC: ~c_in.
- Subtract ops add ~b internally.
- Carry-out between bytes uses 9-bit per-byte addition: byte[i] + addend[i] + carry.
- Flags are computed over the full width:
  - Z: the full 8*NBYTES-bit result is zero. For CP, Z is computed on the difference.
  - N: 1 for SUB, SBC and CP; 0 otherwise.
  - H: the nibble carry out of bit 3 of the most-significant byte. For subtract ops H is inverted (borrow). For NBYTES=2 this is bit 11, per ADD HL,rr.
  - C: the carry out of the MSB. For subtract ops C is inverted (borrow).
  - Logic ops: C=0. H=1 for AND and 0 for XOR/OR. Z is computed on the logic result.
- CP: res is written with the latched a, unchanged. Only the flags reflect the difference.
- Arithmetic wraps modulo 2^(8*NBYTES). There is no overflow flag.

## Timing
- Accepting edge k: busy=1 from cycle k+1 through k+NBYTES.
- done=1 in cycle k+NBYTES+1, for exactly one cycle. res and flags are valid from that cycle onward.
- Latency from the accepting edge to done is NBYTES+1 cycles.
- Throughput is one op per NBYTES+1 cycles when start is held or re-asserted in DONE.
- res and flags hold their values until the next completion; neither an abort nor an accept alone changes them.
- NBYTES=1: RUN lasts exactly one cycle.
- Reset values: busy=0, done=0, res=0, f_z=f_n=f_h=f_c=0, state IDLE.
- rst=1 mid-RUN or in DONE overrides everything, including start and abort in the same cycle.
- abort and start together in RUN: abort wins, and start is ignored that cycle.
- Operand inputs a, b, op and c_in may change freely after the accepting edge.

## Test plan
- NBYTES=2, ADD a=0x0FFF b=0x0001 -> done exactly 3 cycles after accept, res=0x1000, Z0 N0 H1 C0; busy high for exactly 2 cycles.
- NBYTES=2, SUB a=0x0000 b=0x0001 -> res=0xFFFF, Z0 N1 H1 C1; then SBC a=0x0000 b=0x0000 c_in=1 -> res=0xFFFF, Z0 N1 H1 C1.
- NBYTES=2, CP a=0x1234 b=0x1234 -> res=0x1234, Z1 N1 H0 C0; then ADC a=0xFFFF b=0x0000 c_in=1 -> res=0x0000, Z1 N0 H1 C1.
- NBYTES=2, AND a=0xF0F0 b=0x0F0F with start held high through DONE, followed by a back-to-back XOR a=0xAAAA b=0x5555:
  - first op -> res=0x0000, Z1 H1 C0;
  - second op -> accepted in the DONE cycle, res=0xFFFF, Z0 H0, second done 3 cycles later.
- NBYTES=2, abort asserted in the second RUN cycle of ADD 0x0001+0x0001 -> no done, back in IDLE, res/flags unchanged from the prior op. Repeat with rst=1 mid-RUN -> all outputs 0 next cycle.
- NBYTES=1, ADD a=0x3A b=0xC6 -> res=0x00, Z1 N0 H1 C1, done 2 cycles after accept. NBYTES=8, SUB of 1 from 0 -> all-ones result, C1, done 9 cycles after accept.

Source files
------------

// File: rtl/mb_alu.sv
// Serial multi-byte ALU: walks an NBYTES-wide operand pair one byte per clock, LSB first,
// chaining the carry between bytes and producing SM83-style Z/N/H/C flags for the full width.
module mb_alu #(
    parameter int NBYTES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          op,
    input  logic                c_in,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] res,
    output logic                f_z,
    output logic                f_n,
    output logic                f_h,
    output logic                f_c
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_XOR, OP_OR, OP_CP
    } op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   work_q, work_d;
    logic [W-1:0]   res_q, res_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           f_z_q, f_z_d, f_n_q, f_n_d, f_h_q, f_h_d, f_c_q, f_c_d;

    logic           is_sub, is_logic;
    logic [7:0]     a_byte, addend, logic_byte, res_byte;
    logic [8:0]     sum9;
    logic           h_carry;

    // Per-byte datapath on the shifted operands; subtraction adds ~b with an injected carry.
    always_comb begin
        is_sub     = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
        is_logic   = (op_q == OP_AND) || (op_q == OP_XOR) || (op_q == OP_OR);
        a_byte     = a_sh_q[7:0];
        addend     = is_sub ? ~b_sh_q[7:0] : b_sh_q[7:0];
        sum9       = {1'b0, a_byte} + {1'b0, addend} + {8'd0, carry_q};
        h_carry    = sum9[4] ^ a_byte[4] ^ addend[4];
        logic_byte = 8'h00;
        case (op_q)
            OP_AND:  logic_byte = a_byte & b_sh_q[7:0];
            OP_XOR:  logic_byte = a_byte ^ b_sh_q[7:0];
            OP_OR:   logic_byte = a_byte | b_sh_q[7:0];
            default: logic_byte = 8'h00;
        endcase
        res_byte = is_logic ? logic_byte : sum9[7:0];
    end

    always_comb begin
        // NOTE: every *_d defaults to its hold value first, so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        work_d  = work_q;
        res_d   = res_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        f_z_d   = f_z_q;
        f_n_d   = f_n_q;
        f_h_d   = f_h_q;
        f_c_d   = f_c_q;

        case (state_q)
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    // Result bytes enter at the top and slide down, so byte 0 lands at the bottom last.
                    work_d  = (work_q >> 8) | (W'(res_byte) << (W - 8));
                    a_sh_d  = a_sh_q >> 8;
                    b_sh_d  = b_sh_q >> 8;
                    carry_d = sum9[8];
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        res_d   = (op_q == OP_CP) ? a_q : work_d;
                        f_z_d   = (work_d == '0);
                        f_n_d   = is_sub;
                        f_h_d   = is_logic ? (op_q == OP_AND) : (h_carry ^ is_sub);
                        f_c_d   = is_logic ? 1'b0 : (sum9[8] ^ is_sub);
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    op_d    = op_t'(op);
                    a_d     = a;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    case (op_t'(op))
                        OP_ADC:        carry_d = c_in;
                        OP_SUB, OP_CP: carry_d = 1'b1;
                        OP_SBC:        carry_d = ~c_in;
                        default:       carry_d = 1'b0;
                    endcase
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            work_q  <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            f_z_q   <= 1'b0;
            f_n_q   <= 1'b0;
            f_h_q   <= 1'b0;
            f_c_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            work_q  <= work_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            f_z_q   <= f_z_d;
            f_n_q   <= f_n_d;
            f_h_q   <= f_h_d;
            f_c_q   <= f_c_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign f_z  = f_z_q;
    assign f_n  = f_n_q;
    assign f_h  = f_h_q;
    assign f_c  = f_c_q;

endmodule

// File: tb/tb_mb_alu.sv
// Directed bench for mb_alu: 2-byte main instance plus 1-byte and 8-byte instances
// for the width boundaries; expected values are hand-computed.
module tb_mb_alu;

    localparam logic [2:0] ADD = 3'd0, ADC = 3'd1, SUB = 3'd2, SBC = 3'd3,
                           AND = 3'd4, XOR = 3'd5, OR  = 3'd6, CP  = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start2 = 1'b0, abort2 = 1'b0, cin2 = 1'b0;
    logic [2:0]  op2 = ADD;
    logic [15:0] a2 = '0, b2 = '0;
    logic        busy2, done2, z2, n2, h2, c2;
    logic [15:0] res2;

    logic        start1 = 1'b0;
    logic [2:0]  op1 = ADD;
    logic [7:0]  a1 = '0, b1 = '0;
    logic        busy1, done1, z1, n1, h1, c1;
    logic [7:0]  res1;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = ADD;
    logic [63:0] a8 = '0, b8 = '0;
    logic        busy8, done8, z8, n8, h8, c8;
    logic [63:0] res8;

    logic        zero = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mb_alu #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .op(op2), .c_in(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .res(res2),
        .f_z(z2), .f_n(n2), .f_h(h2), .f_c(c2)
    );

    mb_alu #(.NBYTES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(zero), .op(op1), .c_in(zero),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .res(res1),
        .f_z(z1), .f_n(n1), .f_h(h1), .f_c(c1)
    );

    mb_alu #(.NBYTES(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(zero), .op(op8), .c_in(zero),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .res(res8),
        .f_z(z8), .f_n(n8), .f_h(h8), .f_c(c8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one op on the 2-byte instance, scrambles the operand inputs after the
    // accepting edge, and reports cycles-to-done (counting the accept cycle as 1) and busy cycles.
    task automatic launch2(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                           input logic ci, output int lat, output int bcnt);
        op2 = o; a2 = av; b2 = bv; cin2 = ci; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        a2 = 16'h5A5A; b2 = 16'hC3C3; op2 = OR; cin2 = ~ci;
        lat  = 1;
        bcnt = busy2 ? 1 : 0;
        while (!done2 && lat < 40) begin
            tick();
            lat++;
            if (busy2) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy2, done2, res2, z2, n2, h2, c2} !== 22'd0) begin
            errors++;
            $display("FAIL reset2: got busy=%b done=%b res=%h znhc=%b%b%b%b, want all 0",
                     busy2, done2, res2, z2, n2, h2, c2);
        end
        checks++;
        if ({busy1, done1, res1, z1, n1, h1, c1, busy8, done8, res8, z8, n8, h8, c8} !== 86'd0) begin
            errors++;
            $display("FAIL reset1_8: got res1=%h res8=%h busy=%b%b done=%b%b, want all 0",
                     res1, res8, busy1, busy8, done1, done8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add();
        int lat, bcnt;
        launch2(ADD, 16'h0FFF, 16'h0001, 1'b0, lat, bcnt);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL add_latency: got %0d, want 3", lat);
        end
        checks++;
        if (bcnt !== 2) begin
            errors++;
            $display("FAIL add_busy_cycles: got %0d, want 2", bcnt);
        end
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'h1000, 4'b0010}) begin
            errors++;
            $display("FAIL add_result: got res=%h znhc=%b%b%b%b, want 1000 0010", res2, z2, n2, h2, c2);
        end
        tick();
        checks++;
        if ({done2, busy2, res2, z2, n2, h2, c2} !== {2'b00, 16'h1000, 4'b0010}) begin
            errors++;
            $display("FAIL add_hold: got done=%b busy=%b res=%h, want done=0 busy=0 res=1000", done2, busy2, res2);
        end
    endtask

    task automatic test_sub_sbc();
        int lat, bcnt;
        launch2(SUB, 16'h0000, 16'h0001, 1'b0, lat, bcnt);
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'hFFFF, 4'b0111} || lat !== 3) begin
            errors++;
            $display("FAIL sub: got res=%h znhc=%b%b%b%b lat=%0d, want ffff 0111 lat=3", res2, z2, n2, h2, c2, lat);
        end
        tick();
        launch2(SBC, 16'h0000, 16'h0000, 1'b1, lat, bcnt);
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'hFFFF, 4'b0111}) begin
            errors++;
            $display("FAIL sbc: got res=%h znhc=%b%b%b%b, want ffff 0111", res2, z2, n2, h2, c2);
        end
        tick();
    endtask

    task automatic test_cp_adc();
        int lat, bcnt;
        launch2(CP, 16'h1234, 16'h1234, 1'b0, lat, bcnt);
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'h1234, 4'b1100}) begin
            errors++;
            $display("FAIL cp: got res=%h znhc=%b%b%b%b, want 1234 1100", res2, z2, n2, h2, c2);
        end
        tick();
        launch2(ADC, 16'hFFFF, 16'h0000, 1'b1, lat, bcnt);
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'h0000, 4'b1011}) begin
            errors++;
            $display("FAIL adc: got res=%h znhc=%b%b%b%b, want 0000 1011", res2, z2, n2, h2, c2);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        op2 = AND; a2 = 16'hF0F0; b2 = 16'h0F0F; cin2 = 1'b0; start2 = 1'b1;
        tick();
        op2 = XOR; a2 = 16'hAAAA; b2 = 16'h5555;
        n = 1;
        while (!done2 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'h0000, 4'b1010} || n !== 3) begin
            errors++;
            $display("FAIL b2b_and: got res=%h znhc=%b%b%b%b lat=%0d, want 0000 1010 lat=3", res2, z2, n2, h2, c2, n);
        end
        tick();
        start2 = 1'b0;
        checks++;
        if ({busy2, done2} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", busy2, done2);
        end
        n = 1;
        while (!done2 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({res2, z2, n2, h2, c2} !== {16'hFFFF, 4'b0000} || n !== 3) begin
            errors++;
            $display("FAIL b2b_xor: got res=%h znhc=%b%b%b%b gap=%0d, want ffff 0000 gap=3", res2, z2, n2, h2, c2, n);
        end
        tick();
    endtask

    task automatic test_abort_reset();
        int seen;
        op2 = ADD; a2 = 16'h0001; b2 = 16'h0001; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        tick();
        abort2 = 1'b1; start2 = 1'b1;
        tick();
        abort2 = 1'b0; start2 = 1'b0;
        checks++;
        if ({busy2, done2, res2, z2, n2, h2, c2} !== {2'b00, 16'hFFFF, 4'b0000}) begin
            errors++;
            $display("FAIL abort: got busy=%b done=%b res=%h znhc=%b%b%b%b, want 0 0 ffff 0000",
                     busy2, done2, res2, z2, n2, h2, c2);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done2 || busy2) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_idle: got %0d active cycles after abort, want 0", seen);
        end
        start2 = 1'b1;
        tick();
        tick();
        rst = 1'b1; abort2 = 1'b1;
        tick();
        rst = 1'b0; abort2 = 1'b0; start2 = 1'b0;
        checks++;
        if ({busy2, done2, res2, z2, n2, h2, c2} !== 22'd0) begin
            errors++;
            $display("FAIL rst_midrun: got busy=%b done=%b res=%h znhc=%b%b%b%b, want all 0",
                     busy2, done2, res2, z2, n2, h2, c2);
        end
        tick();
        tick();
        checks++;
        if ({busy2, done2} !== 2'b00) begin
            errors++;
            $display("FAIL rst_idle: got busy=%b done=%b, want 0 0", busy2, done2);
        end
    endtask

    task automatic test_widths();
        int n;
        op1 = ADD; a1 = 8'h3A; b1 = 8'hC6; start1 = 1'b1;
        tick();
        start1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
        n = 1;
        while (!done1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({res1, z1, n1, h1, c1} !== {8'h00, 4'b1011} || n !== 2) begin
            errors++;
            $display("FAIL n1_add: got res=%h znhc=%b%b%b%b lat=%0d, want 00 1011 lat=2", res1, z1, n1, h1, c1, n);
        end
        op8 = SUB; a8 = 64'd0; b8 = 64'd1; start8 = 1'b1;
        tick();
        start8 = 1'b0; b8 = 64'd7;
        n = 1;
        while (!done8 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if ({res8, z8, n8, h8, c8} !== {64'hFFFF_FFFF_FFFF_FFFF, 4'b0111} || n !== 9) begin
            errors++;
            $display("FAIL n8_sub: got res=%h znhc=%b%b%b%b lat=%0d, want ffffffffffffffff 0111 lat=9",
                     res8, z8, n8, h8, c8, n);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_sbc();
        test_cp_adc();
        test_back_to_back();
        test_abort_reset();
        test_widths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
